// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: merges load-use stall, EX branch redirect and I-cache miss into
// per-stage enables/flushes and sequences the I-cache refill handshake and replay.
// Define PIPE_PERF_CNT_EN to build the stall/miss/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             stall_i,
    input  logic             br_taken_i,
    input  logic             ic_miss_i,
    input  logic             ic_refill_ack_i,
    output logic             ic_refill_req_o,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             miss_err_o,
    output logic [CNT_W-1:0] stall_cyc_o,
    output logic [CNT_W-1:0] miss_cyc_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int TW = (MISS_TIMEOUT > 2) ? $clog2(MISS_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(MISS_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MISS_WAIT, REPLAY} state_t;

    state_t        state_q;
    logic [TW-1:0] to_cnt_q;
    logic          req_q;
    logic          err_q;
    logic          fetch_busy;

    // A fetch is blocked while refilling/replaying, or on a fresh miss in RUN.
    assign fetch_busy = (state_q != RUN) || ic_miss_i;

    // Stage controls, priority reset > branch > stall > miss/refill > normal.
    always_comb begin
        pc_we_o      = rst_n_i && (br_taken_i || (!stall_i && !fetch_busy));
        ifid_we_o    = rst_n_i && (br_taken_i || !stall_i);
        ifid_flush_o = !rst_n_i || br_taken_i || (!stall_i && fetch_busy);
        idex_flush_o = !rst_n_i || br_taken_i || stall_i;
    end

    // Refill sequencer: request on miss, wait for ack with saturating timeout, replay once.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= RUN;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ic_miss_i && !stall_i && !br_taken_i) begin
                        state_q <= MISS_WAIT;
                        req_q   <= 1'b1;
                    end
                end
                MISS_WAIT: begin
                    if (ic_refill_ack_i) begin
                        state_q  <= REPLAY;
                        req_q    <= 1'b0;
                        to_cnt_q <= '0;
                    end else if (to_cnt_q == TO_MAX) begin
                        err_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TW'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign ic_refill_req_o = req_q;
    assign miss_err_o      = err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cyc_q;
    logic [CNT_W-1:0] miss_cyc_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Free-running wrap-around event counters; a branch masks a coincident stall.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cyc_q <= '0;
            miss_cyc_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (br_taken_i)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (stall_i && !br_taken_i)
                stall_cyc_q <= stall_cyc_q + CNT_W'(1);
            if (state_q != RUN)
                miss_cyc_q <= miss_cyc_q + CNT_W'(1);
        end
    end

    assign stall_cyc_o = stall_cyc_q;
    assign miss_cyc_o  = miss_cyc_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cyc_o = '0;
    assign miss_cyc_o  = '0;
    assign flush_cnt_o = '0;
`endif
endmodule
